uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  Receive half of the debug UART: deserialises 8N1 frames from the FPGA rxd pin
//  into bytes for the CPU UART peripheral (ID_CPU_UART), built when CPU_HAS_UART=1.
//  Mid-bit sampling from a bit-period counter; one-byte holding register with
//  valid/ready handshake; framing and overrun errors reported as one-cycle pulses.
// PARAMETERS
//  CLOCK_FREQUENCY  100_000_000  clk frequency in Hz (sc64::CLOCK_FREQUENCY)
//  BAUD_RATE        1_000_000    line rate in bit/s (sc64::UART_BAUD_RATE)
//  derived: BIT_TICKS = CLOCK_FREQUENCY/BAUD_RATE (100), HALF_TICKS = BIT_TICKS/2 (50)
// PORTS
//  clk           in   1  system clock
//  reset         in   1  asynchronous, active-high reset
//  rxd           in   1  serial input, idle high, asynchronous to clk
//  rx_data       out  8  received byte, stable while rx_valid=1
//  rx_valid      out  1  byte available in holding register
//  rx_ready      in   1  consumer accepts byte when rx_valid && rx_ready
//  frame_error   out  1  1-cycle pulse: stop bit sampled low
//  overrun       out  1  1-cycle pulse: new byte arrived while holding register full
//  parity_error  out  1  1-cycle pulse: parity mismatch (constant 0 without macro)
//  busy          out  1  high in every state except IDLE
// BEHAVIOUR
//  - Reset: rx_data=8'h00, rx_valid/frame_error/overrun/parity_error/busy=0,
//    sync flops=1, state=IDLE, bit counter=0. Reset mid-frame discards partial byte.
//  - rxd passes a 2-flop synchroniser (reset value 1); all logic uses rxd_s.
//  - Counter: loaded on state entry, decrements each clk; sample point at count 0,
//    then reload BIT_TICKS-1. Width $clog2(BIT_TICKS).
//  - IDLE: rxd_s==0 -> START, counter=HALF_TICKS-1.
//  - START: at sample, rxd_s==1 -> IDLE (glitch, no flags); else -> DATA, bit index=0.
//  - DATA: sample 8 bits LSB first into shift register; after bit 7 -> STOP
//    (-> PARITY when macro defined).
//  - STOP: at sample, rxd_s==1 -> deliver byte, -> IDLE. rxd_s==0 -> frame_error
//    pulse, byte discarded, -> BREAK.
//  - BREAK: wait for rxd_s==1, -> IDLE (no new start detected while line held low).
//  - Delivery (cycle after stop sample): if !rx_valid, or rx_valid && rx_ready that
//    cycle -> rx_data=byte, rx_valid=1. If rx_valid && !rx_ready -> overrun pulse,
//    old byte kept, new byte dropped.
//  - Handshake: rx_valid clears the cycle after rx_valid && rx_ready unless a
//    delivery occurs in that same cycle (then stays 1 with new data).
//  - Latency: rx_valid rises 2 (sync) + 1 cycles after mid-stop-bit sample edge.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: frame is 8E1; PARITY state samples 9th bit; if
//    XOR(data,bit)!=0 -> parity_error pulse, byte still delivered; then -> STOP.
//  UART_RX_PARITY_EN undefined: 8N1, no PARITY state, parity_error tied 0.
// TESTING
//  - send 0xA5 8N1 at 100 clk/bit, rx_ready=1 -> rx_valid 1 cycle, rx_data=0xA5, no flags.
//  - rxd low 30 cycles then high -> returns to IDLE, no rx_valid, no flags, busy drops.
//  - 0x3C with stop bit low, rxd held low 500 cycles -> one frame_error pulse,
//    no rx_valid; next 0x55 after release received correctly.
//  - send 0x11 then 0x22, rx_ready=0 -> rx_data=0x11 held, one overrun pulse on 0x22.
//  - rx_ready asserted same cycle as 0x22 delivery -> rx_data=0x22, rx_valid stays 1, no overrun.
//  - reset pulse during bit 4 of 0xFF, then 0x81 -> only 0x81 delivered.
//  - (UART_RX_PARITY_EN) 0x07 with parity bit 0 -> parity_error pulse, rx_data=0x07.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: receive half of the debug UART.
//   Deserialises 8N1 frames (8E1 when UART_RX_PARITY_EN is defined) from the rxd pin into a
//   one-byte holding register with a valid/ready handshake. Each bit is sampled mid-bit by a
//   down-counter. Framing, overrun and parity errors are reported as one-cycle pulses.
// Configuration macro: UART_RX_PARITY_EN (adds an even-parity bit after the data bits).
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   rxd           serial input, idle high, asynchronous to clk
//   rx_data       received byte, stable while rx_valid is high
//   rx_valid      byte available in the holding register
//   rx_ready      consumer accepts the byte when rx_valid && rx_ready
//   frame_error   1-cycle pulse: stop bit sampled low
//   overrun       1-cycle pulse: new byte arrived while the holding register was full
//   parity_error  1-cycle pulse: parity mismatch (tied 0 without UART_RX_PARITY_EN)
//   busy          high whenever the receiver is not idle
module uart_rx #(
   parameter int unsigned CLOCK_FREQUENCY = 100_000_000,
   parameter int unsigned BAUD_RATE       = 1_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_error,
   output logic       overrun,
   output logic       parity_error,
   output logic       busy
);

   localparam int unsigned BitTicks  = CLOCK_FREQUENCY / BAUD_RATE;
   localparam int unsigned HalfTicks = BitTicks / 2;
   localparam int unsigned CntW      = $clog2(BitTicks);

   localparam logic [CntW-1:0] BitReload  = CntW'(BitTicks - 1);
   localparam logic [CntW-1:0] HalfReload = CntW'(HalfTicks - 1);
   localparam logic [CntW-1:0] CntOne     = CntW'(1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
      StParity = 3'd3,
      StStop   = 3'd4,
      StBreak  = 3'd5
   } state_e;
`else
   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StStart = 3'd1,
      StData  = 3'd2,
      StStop  = 3'd4,
      StBreak = 3'd5
   } state_e;
`endif

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            deliver_q, deliver_d;
   logic            frame_err_q, frame_err_d;
   logic [7:0]      rx_data_q, rx_data_d;
   logic            rx_valid_q, rx_valid_d;
   logic            overrun_q, overrun_d;
   logic            rxd_meta_q, rxd_s_q;
   logic            sample;

   // Two-flop synchroniser; resets to the idle line level so reset never looks like a start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rxd_meta_q <= 1'b1;
         rxd_s_q    <= 1'b1;
      end else begin
         rxd_meta_q <= rxd;
         rxd_s_q    <= rxd_meta_q;
      end
   end

   assign sample = (cnt_q == '0);

`ifdef UART_RX_PARITY_EN
   logic par_err_q, par_err_d;
`endif

   // Frame FSM: next state, sampling counter and shift register.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      deliver_d   = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_d   = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            if (!rxd_s_q) begin
               state_d = StStart;
               cnt_d   = HalfReload;
            end
         end
         StStart: begin
            if (sample) begin
               // Line back high at mid start bit: treat as a glitch and drop it silently.
               if (rxd_s_q) begin
                  state_d = StIdle;
               end else begin
                  state_d   = StData;
                  cnt_d     = BitReload;
                  bit_idx_d = 3'd0;
               end
            end else begin
               cnt_d = cnt_q - CntOne;
            end
         end
         StData: begin
            if (sample) begin
               shift_d   = {rxd_s_q, shift_q[7:1]};
               cnt_d     = BitReload;
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end
            end else begin
               cnt_d = cnt_q - CntOne;
            end
         end
`ifdef UART_RX_PARITY_EN
         StParity: begin
            if (sample) begin
               par_err_d = ^{shift_q, rxd_s_q};
               state_d   = StStop;
               cnt_d     = BitReload;
            end else begin
               cnt_d = cnt_q - CntOne;
            end
         end
`endif
         StStop: begin
            if (sample) begin
               if (rxd_s_q) begin
                  deliver_d = 1'b1;
                  state_d   = StIdle;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = StBreak;
               end
            end else begin
               cnt_d = cnt_q - CntOne;
            end
         end
         StBreak: begin
            // Stay here until the line is released so a held-low line is not seen as a start.
            if (rxd_s_q) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Holding register and handshake; a delivery in the accept cycle keeps rx_valid high.
   always_comb begin
      rx_valid_d = rx_valid_q;
      rx_data_d  = rx_data_q;
      overrun_d  = 1'b0;
      if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end
      if (deliver_q) begin
         if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'h00;
         deliver_q   <= 1'b0;
         frame_err_q <= 1'b0;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         deliver_q   <= deliver_d;
         frame_err_q <= frame_err_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         overrun_q   <= overrun_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         par_err_q <= 1'b0;
      end else begin
         par_err_q <= par_err_d;
      end
   end
   assign parity_error = par_err_q;
`else
   assign parity_error = 1'b0;
`endif

   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign frame_error = frame_err_q;
   assign overrun     = overrun_q;
   assign busy        = (state_q != StIdle);

endmodule
